wolfram_ca_engine: RTL and testbench
====================================

# wolfram_ca_engine

Parametrised, clocked elementary cellular-automaton engine. It generalises the fixed three-input Wolfram rule gates of the DNACompiler Wolfram set in three ways: the 8-bit rule is a run-time input, the engine spans an N-cell ring or line, and it iterates a programmed number of generations. The engine sits behind a simple load/start/result handshake, so it can serve as a sequential reference model or golden checker for the per-rule combinational modules.

## Interface
- N_CELLS, 16, number of cells; must be ≥ 3.
- STEP_W, 8, width of the generation count.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- load_valid  in  1  request to load `load_state`.
- load_ready  out  1  high only in IDLE.
- load_state  in  N_CELLS  initial pattern; bit i is cell i.
- start  in  1  start a run; accepted only in IDLE.
- rule  in  8  Wolfram rule number; latched on start.
- wrap  in  1  1 = ring boundary, 0 = constant-zero boundary; latched on start.
- run_steps  in  STEP_W  number of generations; latched on start.
- busy  out  1  high in RUN.
- result_valid  out  1  high in DONE.
- result_ready  in  1  consumer accepts the result.
- state_out  out  N_CELLS  current cell register, visible in every state.
- gen_count  out  STEP_W  generations applied since the last accepted start.

## Operation
- Neighbourhood of cell i:
  - l = cell[i+1], c = cell[i], r = cell[i−1].
  - Next value = rule[{l,c,r}], a 3-bit index with l as MSB.
  - Example: rule 0x99 gives 000→1, 001→0, 011→1.
- Boundary handling:
  - wrap=1: cell[N] ≡ cell[0] and cell[−1] ≡ cell[N−1].
  - wrap=0: both out-of-range neighbours read 0.
- All cells update simultaneously from the pre-edge state.
- FSM states are IDLE, RUN and DONE.
- IDLE:
  - load_valid=1 → cell register ← load_state.
  - start=1 → latch rule, wrap and run_steps; counter ← run_steps; gen_count ← 0; go to RUN.
  - If load_valid and start are both high, the load happens and the run starts from the newly loaded pattern in the same edge.
- RUN:
  - counter==0 → go to DONE.
  - Otherwise apply one generation, decrement the counter and increment gen_count.
  - start and load_valid are ignored.
- DONE:
  - result_valid=1 and state_out is frozen.
  - result_valid & result_ready → go to IDLE.
  - start is ignored until the result is accepted.
- run_steps=0 → RUN for one cycle, then DONE with the pattern unchanged and gen_count=0.
- Rule, wrap and step inputs may change during RUN without effect, because the latched copies are used.
- gen_count saturates naturally: it cannot exceed run_steps, which has the same width.
- Reset (asynchronous, any state, including mid-run):
  - FSM → IDLE; cell register, counter and gen_count → 0.
  - Outputs: busy=0, result_valid=0, load_ready=1, state_out=0, gen_count=0.

## Timing
- Load: pattern is visible on state_out one cycle after the load_valid edge.
- Start accepted at edge 0:
  - Generations are applied at edges 1..S, where S = run_steps.
  - The FSM enters DONE at edge S+1, so result_valid is high S+1 cycles after start.
- Throughput is one generation per clock.
- The next generation is purely combinational from registered state; no pipeline bubbles.
- Back-to-back runs:
  - Accept at edge k → IDLE.
  - A new start is possible at edge k+1.
  - A new run continues from the retained pattern unless reloaded.

## Structure
- Package wolfram_ca_pkg:
  - FSM state enum (IDLE, RUN, DONE).
  - RULE_W = 8.
  - Helper function rule_lookup(rule, l, c, r).
- Sub-module wolfram_rule_cell: purely combinational. It takes rule, l, c and r and returns the next value. The engine instantiates it N_CELLS times in a generate loop, with the boundary muxing done in the parent.

## Test plan
- Rule 0x99, N=8, wrap=1, load 0x01, steps=1 → state_out=0xFC and gen_count=1; result_valid high exactly 2 cycles after start.
- Rule 0x5A (rule 90), N=8, load 0x01, steps=1 → 0x82 with wrap=1 and 0x02 with wrap=0.
- Rule 0x99, load 0x00, steps=3 → 0xFF (0x00→0xFF→0xFF→0xFF); busy high 4 cycles; gen_count=3.
- steps=0 with rule 0xCC and pattern 0xA5 → DONE after 1 cycle, 0xA5 unchanged, gen_count=0.
- Hold result_ready=0 for 5 cycles in DONE:
  - result_valid and state_out stay stable.
  - start and load pulses during RUN/DONE are ignored.
  - Accept → IDLE, and load_ready=1 next cycle.
- Assert rst mid-run (rule 0x99, steps=10, after 4 generations):
  - Outputs go to 0 and IDLE without waiting for a clock edge.
  - A fresh load and start after reset behaves identically to the first scenario.

Source files
------------

// File: rtl/wolfram_ca_pkg.sv
// Shared types and helpers for the elementary cellular-automaton engine.
package wolfram_ca_pkg;

    localparam int RULE_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } ca_state_t;

    // Wolfram rule lookup: the neighbourhood {l,c,r} indexes the rule byte, l is the MSB.
    function automatic logic rule_lookup(input logic [RULE_W-1:0] rule_v,
                                         input logic l, input logic c, input logic r);
        return rule_v[{l, c, r}];
    endfunction

endpackage

// File: rtl/wolfram_ca_engine_rule_cell.sv
// One cell's next-state function; purely combinational.
module wolfram_rule_cell
    import wolfram_ca_pkg::*;
(
    input  logic [RULE_W-1:0] rule,
    input  logic              l,
    input  logic              c,
    input  logic              r,
    output logic              nxt
);

    assign nxt = rule_lookup(rule, l, c, r);

endmodule

// File: rtl/wolfram_ca_engine.sv
// Clocked elementary cellular-automaton engine: load a pattern, start a run of
// a programmed number of generations under a latched rule, then hand back the result.
//
// Handshakes: a load is taken on any edge where load_valid & load_ready; a start is
// taken on any edge where start is high while load_ready (IDLE) is high; a result is
// handed over on the edge where result_valid & result_ready. Inputs outside those
// windows are ignored.
module wolfram_ca_engine
    import wolfram_ca_pkg::*;
#(
    parameter int N_CELLS = 16,
    parameter int STEP_W  = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_valid,
    output logic               load_ready,
    input  logic [N_CELLS-1:0] load_state,
    input  logic               start,
    input  logic [RULE_W-1:0]  rule,
    input  logic               wrap,
    input  logic [STEP_W-1:0]  run_steps,
    output logic               busy,
    output logic               result_valid,
    input  logic               result_ready,
    output logic [N_CELLS-1:0] state_out,
    output logic [STEP_W-1:0]  gen_count
);

    ca_state_t          state_q, state_d;
    logic [N_CELLS-1:0] cells_q, cells_d;
    logic [STEP_W-1:0]  counter_q, counter_d;
    logic [STEP_W-1:0]  gen_q, gen_d;
    logic [RULE_W-1:0]  rule_q, rule_d;
    logic               wrap_q, wrap_d;
    logic [N_CELLS-1:0] next_cells;

    // Next generation, built from registered state only; edge cells see the
    // opposite end of the register when wrapping, otherwise a constant zero.
    for (genvar i = 0; i < N_CELLS; i++) begin : g_cell
        logic l_bit;
        logic r_bit;
        if (i == N_CELLS - 1) begin : g_left_edge
            assign l_bit = wrap_q & cells_q[0];
        end else begin : g_left_mid
            assign l_bit = cells_q[i+1];
        end
        if (i == 0) begin : g_right_edge
            assign r_bit = wrap_q & cells_q[N_CELLS-1];
        end else begin : g_right_mid
            assign r_bit = cells_q[i-1];
        end
        wolfram_rule_cell u_cell (
            .rule (rule_q),
            .l    (l_bit),
            .c    (cells_q[i]),
            .r    (r_bit),
            .nxt  (next_cells[i])
        );
    end

    // State and datapath registers with asynchronous reset to an empty, idle engine.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cells_q   <= '0;
            counter_q <= '0;
            gen_q     <= '0;
            rule_q    <= '0;
            wrap_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cells_q   <= cells_d;
            counter_q <= counter_d;
            gen_q     <= gen_d;
            rule_q    <= rule_d;
            wrap_q    <= wrap_d;
        end
    end

    // Next-state logic: a run lasts counter+1 cycles, DONE holds until accepted.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start)               state_d = RUN;
            RUN:     if (counter_q == '0)     state_d = DONE;
            DONE:    if (result_ready)        state_d = IDLE;
            default:                          state_d = IDLE;
        endcase
    end

    // Datapath updates: load/latch in IDLE, one generation per RUN cycle, frozen otherwise.
    always_comb begin
        cells_d   = cells_q;
        counter_d = counter_q;
        gen_d     = gen_q;
        rule_d    = rule_q;
        wrap_d    = wrap_q;
        case (state_q)
            IDLE: begin
                if (load_valid) cells_d = load_state;
                if (start) begin
                    rule_d    = rule;
                    wrap_d    = wrap;
                    counter_d = run_steps;
                    gen_d     = '0;
                end
            end
            RUN: begin
                if (counter_q != '0) begin
                    cells_d   = next_cells;
                    counter_d = counter_q - STEP_W'(1);
                    gen_d     = gen_q + STEP_W'(1);
                end
            end
            default: ;
        endcase
    end

    // Outputs decoded from the current state and registers.
    always_comb begin
        load_ready   = (state_q == IDLE);
        busy         = (state_q == RUN);
        result_valid = (state_q == DONE);
        state_out    = cells_q;
        gen_count    = gen_q;
    end

endmodule

// File: tb/tb_wolfram_ca_engine.sv
module tb_wolfram_ca_engine;

  logic       clk;
  logic       rst;
  logic       load_valid;
  logic       load_ready;
  logic [7:0] load_state;
  logic       start;
  logic [7:0] rule_i;
  logic       wrap_i;
  logic [7:0] run_steps;
  logic       busy;
  logic       result_valid;
  logic       result_ready;
  logic [7:0] state_out;
  logic [7:0] gen_count;

  int n_total = 0;
  int n_pass  = 0;
  logic [15:0] exp_q[$];

  wolfram_ca_engine #(.N_CELLS(8), .STEP_W(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .load_valid   (load_valid),
    .load_ready   (load_ready),
    .load_state   (load_state),
    .start        (start),
    .rule         (rule_i),
    .wrap         (wrap_i),
    .run_steps    (run_steps),
    .busy         (busy),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .state_out    (state_out),
    .gen_count    (gen_count)
  );

  // clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic void check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endfunction

  // result monitor: pops an expectation on every result handshake
  always @(negedge clk) begin
    logic [15:0] e;
    if (!rst && result_valid && result_ready) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_result: state 0x%0h with no expectation", state_out);
      end else begin
        e = exp_q.pop_front();
        check("result_state", int'(state_out), int'(e[7:0]));
        check("result_gen", int'(gen_count), int'(e[15:8]));
      end
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input logic do_load, input logic [7:0] pat, input logic [7:0] r,
                           input logic w, input logic [7:0] s, input logic [7:0] exp_s,
                           input logic [7:0] exp_g, input logic disturb);
    int n;
    int busy_cnt;
    exp_q.push_back({exp_g, exp_s});
    load_valid = do_load;
    load_state = pat;
    rule_i     = r;
    wrap_i     = w;
    run_steps  = s;
    start      = 1'b1;
    cycle();
    start      = 1'b0;
    load_valid = 1'b0;
    rule_i     = ~r;
    wrap_i     = ~w;
    run_steps  = 8'hFF;
    if (disturb) begin
      start      = 1'b1;
      load_valid = 1'b1;
      load_state = 8'hFF;
    end
    n = 0;
    busy_cnt = busy ? 1 : 0;
    while (!result_valid && n < 300) begin
      cycle();
      n++;
      if (busy) busy_cnt++;
    end
    check("done_latency", n, int'(s) + 1);
    check("busy_cycles", busy_cnt, int'(s) + 1);
  endtask

  task automatic accept(input int hold, input logic [7:0] exp_s);
    for (int i = 0; i < hold; i++) begin
      check("hold_valid", int'(result_valid), 1);
      check("hold_state", int'(state_out), int'(exp_s));
      cycle();
    end
    start        = 1'b0;
    load_valid   = 1'b0;
    load_state   = 8'h00;
    result_ready = 1'b1;
    cycle();
    result_ready = 1'b0;
    check("accept_load_ready", int'(load_ready), 1);
    check("accept_valid_low", int'(result_valid), 0);
  endtask

  // stimulus
  initial begin
    rst          = 1'b1;
    load_valid   = 1'b0;
    load_state   = 8'h00;
    start        = 1'b0;
    rule_i       = 8'h00;
    wrap_i       = 1'b0;
    run_steps    = 8'h00;
    result_ready = 1'b0;
    #23;
    check("rst_state_out", int'(state_out), 0);
    check("rst_gen_count", int'(gen_count), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_valid", int'(result_valid), 0);
    check("rst_load_ready", int'(load_ready), 1);
    cycle();
    rst = 1'b0;
    cycle();

    start_run(1'b1, 8'h01, 8'h99, 1'b1, 8'd1, 8'hFC, 8'd1, 1'b0);
    accept(0, 8'hFC);
    start_run(1'b1, 8'h01, 8'h5A, 1'b1, 8'd1, 8'h82, 8'd1, 1'b0);
    accept(0, 8'h82);
    start_run(1'b1, 8'h01, 8'h5A, 1'b0, 8'd1, 8'h02, 8'd1, 1'b0);
    accept(0, 8'h02);
    start_run(1'b1, 8'h00, 8'h99, 1'b1, 8'd3, 8'hFF, 8'd3, 1'b0);
    accept(0, 8'hFF);
    start_run(1'b0, 8'h00, 8'h5A, 1'b0, 8'd1, 8'h81, 8'd1, 1'b0);
    accept(0, 8'h81);
    start_run(1'b1, 8'hA5, 8'hCC, 1'b0, 8'd0, 8'hA5, 8'd0, 1'b0);
    accept(0, 8'hA5);
    start_run(1'b1, 8'h01, 8'h5A, 1'b1, 8'd3, 8'hAA, 8'd3, 1'b1);
    accept(5, 8'hAA);

    // asynchronous reset in the middle of a long run
    load_valid = 1'b1;
    load_state = 8'h01;
    start      = 1'b1;
    rule_i     = 8'h99;
    wrap_i     = 1'b1;
    run_steps  = 8'd10;
    cycle();
    load_valid = 1'b0;
    start      = 1'b0;
    repeat (4) cycle();
    check("midrun_gen", int'(gen_count), 4);
    check("midrun_busy", int'(busy), 1);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_state", int'(state_out), 0);
    check("async_rst_gen", int'(gen_count), 0);
    check("async_rst_busy", int'(busy), 0);
    check("async_rst_valid", int'(result_valid), 0);
    check("async_rst_load_ready", int'(load_ready), 1);
    cycle();
    rst = 1'b0;
    cycle();
    start_run(1'b1, 8'h01, 8'h99, 1'b1, 8'd1, 8'hFC, 8'd1, 1'b0);
    accept(0, 8'hFC);

    repeat (3) cycle();
    check("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
